// File: rtl/fetch_unit_pkg.sv
// Shared core definitions for the fetch path: word/address widths, reset PC and buffer entry layout.
package fetch_unit_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned ENTRY_W = ADDR_W + WORD_W;
    // Wide enough for a count of up to 4 entries plus one in-flight read.
    localparam int unsigned CNT_W = 3;
    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 16'h0000;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of {pc, instr} entries between the icache return and decode.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    output logic [ENTRY_W-1:0] head,
    output logic [CNT_W-1:0]   count
);

    localparam int unsigned PTR_W = (DEPTH > 2) ? 2 : 1;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Stale entries stay in memory after a flush; the empty case forces zeros out.
    assign head  = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues sequential icache reads, buffers returned words, handles redirects.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned       DEPTH    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    output logic              ic_r_en,
    output logic [ADDR_W-1:0] ic_addr,
    input  logic [WORD_W-1:0] ic_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [WORD_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc
);

    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  pc_d;
    logic [ADDR_W-1:0]  inflight_pc_q;
    logic               inflight_q;
    logic [CNT_W-1:0]   count;
    logic [CNT_W:0]     occupancy;
    logic               pop;
    logic               issue;
    logic               push;
    fetch_entry_t       push_entry;
    fetch_entry_t       head_entry;
    logic [ENTRY_W-1:0] head_bits;

    assign instr_valid = (count != '0);
    assign pop         = instr_valid & instr_ready;

    always_comb begin
        occupancy = {1'b0, count} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);
        // Gated by reset so no read is requested while reset is held.
        issue = reset & fetch_en & ~redirect_valid & (occupancy < (CNT_W + 1)'(DEPTH));
        // A redirect kills the read whose data is returning now, so it is never pushed.
        push  = inflight_q & ~redirect_valid;
        pc_d  = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (issue) begin
            pc_d = next_pc(pc_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= issue;
            if (issue) begin
                inflight_pc_q <= pc_q;
            end
        end
    end

    assign push_entry = '{pc: inflight_pc_q, instr: ic_data};

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (redirect_valid),
        .push     (push),
        .push_data(push_entry),
        .pop      (pop),
        .head     (head_bits),
        .count    (count)
    );

    assign head_entry = fetch_entry_t'(head_bits);
    assign ic_r_en    = issue;
    assign ic_addr    = pc_q;
    assign instr      = head_entry.instr;
    assign instr_pc   = head_entry.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a one-cycle icache model returning mem[i] = i.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        fetch_en;
    logic        ic_r_en;
    logic [15:0] ic_addr;
    logic [15:0] ic_data;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] instr_pc;

    int total;
    int bad;

    fetch_unit #(
        .RESET_PC(16'h0000),
        .DEPTH   (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_en      (fetch_en),
        .ic_r_en       (ic_r_en),
        .ic_addr       (ic_addr),
        .ic_data       (ic_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ic_r_en) ic_data <= ic_addr;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds reset for two cycles then releases it; returns settled inside cycle C0.
    task automatic start(input logic ready);
        reset = 1'b0;
        fetch_en = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 16'h0000;
        instr_ready = ready;
        tick();
        tick();
        reset = 1'b1;
        fetch_en = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        fetch_en = 1'b1;
        instr_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 16'h0000;
        tick();
        #1;
        total++; if (ic_r_en !== 1'b0) begin bad++; $display("FAIL reset_ic_r_en got=%b want=0", ic_r_en); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", instr_valid); end
        total++; if (instr !== 16'h0000) begin bad++; $display("FAIL reset_instr got=%h want=0000", instr); end
        total++; if (instr_pc !== 16'h0000) begin bad++; $display("FAIL reset_instr_pc got=%h want=0000", instr_pc); end
        total++; if (ic_addr !== 16'h0000) begin bad++; $display("FAIL reset_ic_addr got=%h want=0000", ic_addr); end
    endtask

    task automatic test_stream();
        start(1'b1);
        total++; if (ic_r_en !== 1'b1 || ic_addr !== 16'h0000) begin bad++; $display("FAIL stream_first_issue got=%b/%h want=1/0000", ic_r_en, ic_addr); end
        tick(); #1;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL stream_c1_valid got=%b want=0", instr_valid); end
        for (int k = 0; k < 4; k++) begin
            tick(); #1;
            total++;
            if (instr_valid !== 1'b1 || instr !== 16'(k) || instr_pc !== 16'(k)) begin
                bad++; $display("FAIL stream_pop%0d got=%b/%h/%h want=1/%h/%h", k, instr_valid, instr, instr_pc, 16'(k), 16'(k));
            end
        end
    endtask

    task automatic test_backpressure();
        start(1'b0);
        tick(); #1;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL bp_c1_valid got=%b want=0", instr_valid); end
        for (int c = 2; c <= 6; c++) begin
            tick(); #1;
            total++;
            if (instr_valid !== 1'b1 || instr !== 16'h0000 || instr_pc !== 16'h0000 || ic_r_en !== 1'b0) begin
                bad++; $display("FAIL bp_hold_c%0d got=%b/%h/%h ren=%b want=1/0000/0000 ren=0", c, instr_valid, instr, instr_pc, ic_r_en);
            end
        end
        tick(); instr_ready = 1'b1; #1;
        total++; if (ic_r_en !== 1'b1 || ic_addr !== 16'h0002) begin bad++; $display("FAIL bp_resume_issue got=%b/%h want=1/0002", ic_r_en, ic_addr); end
        total++; if (instr !== 16'h0000 || instr_valid !== 1'b1) begin bad++; $display("FAIL bp_release0 got=%b/%h want=1/0000", instr_valid, instr); end
        for (int k = 1; k < 3; k++) begin
            tick(); #1;
            total++;
            if (instr_valid !== 1'b1 || instr !== 16'(k) || instr_pc !== 16'(k)) begin
                bad++; $display("FAIL bp_release%0d got=%b/%h/%h want=1/%h/%h", k, instr_valid, instr, instr_pc, 16'(k), 16'(k));
            end
        end
    endtask

    task automatic test_redirect();
        start(1'b1);
        tick(); tick(); tick(); tick();
        redirect_valid = 1'b1;
        redirect_pc = 16'h0040;
        #1;
        total++; if (ic_r_en !== 1'b0) begin bad++; $display("FAIL redir_no_issue got=%b want=0", ic_r_en); end
        total++; if (instr !== 16'h0002 || instr_valid !== 1'b1) begin bad++; $display("FAIL redir_pop_same got=%b/%h want=1/0002", instr_valid, instr); end
        tick(); redirect_valid = 1'b0; #1;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL redir_flushed got=%b want=0", instr_valid); end
        total++; if (ic_r_en !== 1'b1 || ic_addr !== 16'h0040) begin bad++; $display("FAIL redir_target_issue got=%b/%h want=1/0040", ic_r_en, ic_addr); end
        tick(); #1;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL redir_killed got=%b/%h want=0", instr_valid, instr); end
        tick(); #1;
        total++; if (instr_valid !== 1'b1 || instr !== 16'h0040 || instr_pc !== 16'h0040) begin bad++; $display("FAIL redir_target got=%b/%h/%h want=1/0040/0040", instr_valid, instr, instr_pc); end
        tick(); #1;
        total++; if (instr !== 16'h0041 || instr_pc !== 16'h0041) begin bad++; $display("FAIL redir_next got=%h/%h want=0041/0041", instr, instr_pc); end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_pc [3];
        exp_pc[0] = 16'hFFFF;
        exp_pc[1] = 16'h0000;
        exp_pc[2] = 16'h0001;
        start(1'b1);
        redirect_valid = 1'b1;
        redirect_pc = 16'hFFFF;
        #1;
        tick(); redirect_valid = 1'b0; #1;
        total++; if (ic_addr !== 16'hFFFF || ic_r_en !== 1'b1) begin bad++; $display("FAIL wrap_issue got=%b/%h want=1/ffff", ic_r_en, ic_addr); end
        tick(); tick(); #1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (instr_valid !== 1'b1 || instr_pc !== exp_pc[k] || instr !== exp_pc[k]) begin
                bad++; $display("FAIL wrap_seq%0d got=%b/%h/%h want=1/%h/%h", k, instr_valid, instr_pc, instr, exp_pc[k], exp_pc[k]);
            end
            tick(); #1;
        end
    endtask

    task automatic test_halt();
        start(1'b1);
        tick(); tick(); fetch_en = 1'b0; #1;
        total++; if (ic_r_en !== 1'b0 || instr !== 16'h0000) begin bad++; $display("FAIL halt_c2 got=%b/%h want=0/0000", ic_r_en, instr); end
        tick(); #1;
        total++; if (instr_valid !== 1'b1 || instr !== 16'h0001 || ic_r_en !== 1'b0) begin bad++; $display("FAIL halt_inflight got=%b/%h ren=%b want=1/0001 ren=0", instr_valid, instr, ic_r_en); end
        tick(); #1;
        total++; if (instr_valid !== 1'b0 || ic_r_en !== 1'b0) begin bad++; $display("FAIL halt_idle got=%b ren=%b want=0 ren=0", instr_valid, ic_r_en); end
        tick(); fetch_en = 1'b1; #1;
        total++; if (ic_r_en !== 1'b1 || ic_addr !== 16'h0002) begin bad++; $display("FAIL halt_resume got=%b/%h want=1/0002", ic_r_en, ic_addr); end
        tick(); tick(); #1;
        total++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0002) begin bad++; $display("FAIL halt_resume_pop got=%b/%h want=1/0002", instr_valid, instr_pc); end
    endtask

    task automatic test_midstream_reset();
        start(1'b0);
        tick(); tick(); tick(); #1;
        total++; if (instr_valid !== 1'b1 || ic_r_en !== 1'b0) begin bad++; $display("FAIL mrst_full got=%b ren=%b want=1 ren=0", instr_valid, ic_r_en); end
        tick(); reset = 1'b0; #1;
        total++; if (instr_valid !== 1'b0 || instr !== 16'h0000 || instr_pc !== 16'h0000) begin bad++; $display("FAIL mrst_cleared got=%b/%h/%h want=0/0000/0000", instr_valid, instr, instr_pc); end
        tick(); reset = 1'b1; instr_ready = 1'b1; #1;
        total++; if (ic_r_en !== 1'b1 || ic_addr !== 16'h0000) begin bad++; $display("FAIL mrst_issue got=%b/%h want=1/0000", ic_r_en, ic_addr); end
        tick(); #1;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL mrst_c1_valid got=%b want=0", instr_valid); end
        tick(); #1;
        total++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0000 || instr !== 16'h0000) begin bad++; $display("FAIL mrst_first got=%b/%h/%h want=1/0000/0000", instr_valid, instr_pc, instr); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        ic_data = 16'h0000;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_halt();
        test_midstream_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
